// File: rtl/i2s_tx_2ch_if.sv
// rtl/i2s_tx_2ch_if.sv - pop/ack handshake between the I2S transmitter and two resampler channels
interface i2s_tx_2ch_if;
  logic        pop_o;
  logic [23:0] data_l_i;
  logic        ack_l_i;
  logic [23:0] data_r_i;
  logic        ack_r_i;

  modport master (output pop_o, input data_l_i, ack_l_i, data_r_i, ack_r_i);
  modport slave  (input pop_o, output data_l_i, ack_l_i, data_r_i, ack_r_i);
endinterface

// File: rtl/i2s_tx_2ch.sv
// rtl/i2s_tx_2ch.sv - stereo I2S transmitter with double-buffered samples and sticky underrun
module i2s_tx_2ch #(
  parameter int CLKDIV = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  i2s_tx_2ch_if.master rs,
  output logic         bck_o,
  output logic         lrck_o,
  output logic         sd_o,
  output logic         underrun_o
);

  localparam int DW = (CLKDIV > 1) ? $clog2(CLKDIV) : 1;
  localparam logic [DW-1:0] DIV_LAST = DW'(CLKDIV - 1);

  logic [DW-1:0] r_div_cnt;
  logic          r_bck;
  logic [5:0]    r_bit_cnt;
  logic          r_lrck;
  logic          r_sd;
  logic          r_pop;
  logic          r_underrun;
  logic          r_primed;
  logic [23:0]   r_shadow_l;
  logic [23:0]   r_shadow_r;
  logic          r_valid_l;
  logic          r_valid_r;
  logic [23:0]   r_word_l;
  logic [23:0]   r_word_r;

  logic          w_div_last;
  logic          w_fall;
  logic          w_frame_start;
  logic [5:0]    w_bit_nxt;
  logic [4:0]    w_pos;
  logic [4:0]    w_idx;
  logic [23:0]   w_word_sel;
  logic          w_sd_nxt;

  assign w_div_last    = (r_div_cnt == DIV_LAST);
  assign w_fall        = w_div_last & r_bck;
  assign w_bit_nxt     = r_bit_cnt + 6'd1;
  assign w_frame_start = w_fall & (r_bit_cnt == 6'd63);
  assign w_pos         = w_bit_nxt[4:0];
  assign w_idx         = 5'd24 - w_pos;
  assign w_word_sel    = w_bit_nxt[5] ? r_word_r : r_word_l;
  // Slot bit 0 is the one-BCK I2S delay; bits 25..31 pad the 24-bit word
  assign w_sd_nxt      = (w_pos >= 5'd1 && w_pos <= 5'd24) ? w_word_sel[w_idx] : 1'b0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_div_cnt  <= '0;
      r_bck      <= 1'b0;
      r_bit_cnt  <= 6'd63;
      r_lrck     <= 1'b1;
      r_sd       <= 1'b0;
      r_pop      <= 1'b0;
      r_underrun <= 1'b0;
      r_primed   <= 1'b0;
      r_word_l   <= '0;
      r_word_r   <= '0;
    end else begin
      r_pop <= w_frame_start;
      if (w_div_last) begin
        r_div_cnt <= '0;
        r_bck     <= ~r_bck;
      end else begin
        r_div_cnt <= r_div_cnt + DW'(1);
      end
      if (w_fall) begin
        r_bit_cnt <= w_bit_nxt;
        r_lrck    <= w_bit_nxt[5];
        r_sd      <= w_sd_nxt;
      end
      if (w_frame_start) begin
        r_word_l <= r_valid_l ? r_shadow_l : 24'd0;
        r_word_r <= r_valid_r ? r_shadow_r : 24'd0;
        r_primed <= 1'b1;
        if (r_primed && !(r_valid_l && r_valid_r)) begin
          r_underrun <= 1'b1;
        end
      end
    end
  end

  // An ack coinciding with frame start wins over the clear, so its data goes to the next frame
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_shadow_l <= '0;
      r_shadow_r <= '0;
      r_valid_l  <= 1'b0;
      r_valid_r  <= 1'b0;
    end else begin
      if (rs.ack_l_i) begin
        r_shadow_l <= rs.data_l_i;
        r_valid_l  <= 1'b1;
      end else if (w_frame_start) begin
        r_valid_l  <= 1'b0;
      end
      if (rs.ack_r_i) begin
        r_shadow_r <= rs.data_r_i;
        r_valid_r  <= 1'b1;
      end else if (w_frame_start) begin
        r_valid_r  <= 1'b0;
      end
    end
  end

  assign rs.pop_o   = r_pop;
  assign bck_o      = r_bck;
  assign lrck_o     = r_lrck;
  assign sd_o       = r_sd;
  assign underrun_o = r_underrun;

endmodule
